r_return_router: RTL



---
 rtl/r_return_router.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/r_return_router.sv
// AXI R-channel return router: three slave R ports arbitrated round-robin onto
// three master R ports, steered by the master tag in the slave ID's upper nibble.
module r_return_router #(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDS_W-1:0]  ID_S0,
  input  logic [IDS_W-1:0]  ID_S1,
  input  logic [IDS_W-1:0]  ID_S2,
  input  logic [DATA_W-1:0] DATA_S0,
  input  logic [DATA_W-1:0] DATA_S1,
  input  logic [DATA_W-1:0] DATA_S2,
  input  logic [1:0]        RESP_S0,
  input  logic [1:0]        RESP_S1,
  input  logic [1:0]        RESP_S2,
  input  logic              LAST_S0,
  input  logic              LAST_S1,
  input  logic              LAST_S2,
  input  logic              VALID_S0,
  input  logic              VALID_S1,
  input  logic              VALID_S2,
  output logic              READY_S0,
  output logic              READY_S1,
  output logic              READY_S2,
  output logic [ID_W-1:0]   ID_M0,
  output logic [ID_W-1:0]   ID_M1,
  output logic [ID_W-1:0]   ID_M2,
  output logic [DATA_W-1:0] DATA_M0,
  output logic [DATA_W-1:0] DATA_M1,
  output logic [DATA_W-1:0] DATA_M2,
  output logic [1:0]        RESP_M0,
  output logic [1:0]        RESP_M1,
  output logic [1:0]        RESP_M2,
  output logic              LAST_M0,
  output logic              LAST_M1,
  output logic              LAST_M2,
  output logic              VALID_M0,
  output logic              VALID_M1,
  output logic              VALID_M2,
  input  logic              READY_M0,
  input  logic              READY_M1,
  input  logic              READY_M2,
  output logic [1:0]        occupied_S,
  output logic [7:0]        beat_cnt,
  output logic              dec_err
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_nxt;
  logic [1:0] lock_s, lock_nxt;
  logic [1:0] rr_ptr, rr_nxt;
  logic [7:0] cnt_nxt;
  logic       derr_nxt;

  logic [IDS_W-1:0]  id_s   [3];
  logic [DATA_W-1:0] data_s [3];
  logic [1:0]        resp_s [3];
  logic [2:0]        last_s, valid_s, ready_m;

  logic [ID_W-1:0]   id_m   [3];
  logic [DATA_W-1:0] data_m [3];
  logic [1:0]        resp_m [3];
  logic [2:0]        last_m, valid_m, ready_s;

  logic        gnt_vld, tgt_ok, hs;
  logic [1:0]  gnt, gnt_inc, tgt;
  logic [3:0]  tag;
  int unsigned idx;

  assign id_s[0]   = ID_S0;
  assign id_s[1]   = ID_S1;
  assign id_s[2]   = ID_S2;
  assign data_s[0] = DATA_S0;
  assign data_s[1] = DATA_S1;
  assign data_s[2] = DATA_S2;
  assign resp_s[0] = RESP_S0;
  assign resp_s[1] = RESP_S1;
  assign resp_s[2] = RESP_S2;
  assign last_s    = {LAST_S2, LAST_S1, LAST_S0};
  assign valid_s   = {VALID_S2, VALID_S1, VALID_S0};
  assign ready_m   = {READY_M2, READY_M1, READY_M0};

  assign {READY_S2, READY_S1, READY_S0} = ready_s;
  assign {VALID_M2, VALID_M1, VALID_M0} = valid_m;
  assign {LAST_M2, LAST_M1, LAST_M0}    = last_m;
  assign ID_M0   = id_m[0];
  assign ID_M1   = id_m[1];
  assign ID_M2   = id_m[2];
  assign DATA_M0 = data_m[0];
  assign DATA_M1 = data_m[1];
  assign DATA_M2 = data_m[2];
  assign RESP_M0 = resp_m[0];
  assign RESP_M1 = resp_m[1];
  assign RESP_M2 = resp_m[2];

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    if (state == BURST) begin
      gnt_vld = 1'b1;
      gnt     = lock_s;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        idx = (32'(rr_ptr) + k) % 3;
        if (!gnt_vld && valid_s[idx]) begin
          gnt_vld = 1'b1;
          gnt     = 2'(idx);
        end
      end
    end

    tag    = id_s[gnt][IDS_W-1 -: 4];
    tgt_ok = (tag == 4'd1) || (tag == 4'd2) || (tag == 4'd3);
    tgt    = tag[1:0] - 2'd1;

    ready_s = '0;
    valid_m = '0;
    last_m  = '0;
    for (int unsigned m = 0; m < 3; m++) begin
      id_m[m]   = '0;
      data_m[m] = '0;
      resp_m[m] = '0;
    end

    // Everything is gated by rst so outputs drop immediately on async reset.
    if (rst && gnt_vld) begin
      if (tgt_ok) begin
        valid_m[tgt] = valid_s[gnt];
        id_m[tgt]    = id_s[gnt][ID_W-1:0];
        data_m[tgt]  = data_s[gnt];
        resp_m[tgt]  = resp_s[gnt];
        last_m[tgt]  = last_s[gnt];
        ready_s[gnt] = ready_m[tgt];
      end else begin
        ready_s[gnt] = 1'b1;
      end
    end

    hs         = gnt_vld && valid_s[gnt] && ready_s[gnt];
    occupied_S = (rst && gnt_vld) ? gnt + 2'd1 : '0;
    gnt_inc    = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;

    state_nxt = state;
    lock_nxt  = lock_s;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    derr_nxt  = hs && !tgt_ok;

    if (hs) begin
      if (last_s[gnt]) cnt_nxt = '0;
      else if (beat_cnt != '1) cnt_nxt = beat_cnt + 8'd1;
    end

    case (state)
      IDLE: begin
        if (gnt_vld) begin
          if (hs && last_s[gnt]) begin
            rr_nxt = gnt_inc;
          end else begin
            state_nxt = BURST;
            lock_nxt  = gnt;
          end
        end
      end
      BURST: begin
        if (hs && last_s[gnt]) begin
          state_nxt = IDLE;
          rr_nxt    = gnt_inc;
          lock_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lock_s   <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      dec_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_s   <= lock_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
      dec_err  <= derr_nxt;
    end
  end

endmodule
